// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the fetch PC, reads the program ROM and queues
// {instruction, pc} pairs in a small prefetch FIFO for the decode stage.
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] PcAddress,
    input  logic [DATA_WIDTH-1:0] Instruction,
    input  logic                  Halt,
    input  logic                  Redirect,
    input  logic [DATA_WIDTH-1:0] RedirectTarget,
    output logic                  InstrValid,
    output logic [DATA_WIDTH-1:0] InstrOut,
    output logic [DATA_WIDTH-1:0] InstrPc,
    input  logic                  DecodeReady,
    output logic                  MisalignErr,
    output logic [DATA_WIDTH-1:0] FetchCount
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    valid_q;
    logic                    misalign_q;
    logic [DATA_WIDTH-1:0]   fetch_count_q;
    logic [DATA_WIDTH-1:0]   instr_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   pc_mem_q    [FIFO_DEPTH];

    logic pop;
    logic push;

    // A pop frees a slot in the same cycle, so a full FIFO keeps streaming.
    assign pop  = valid_q & DecodeReady;
    assign push = (state_q == ST_RUN) & ~Halt & ~Redirect &
                  ((count_q < DEPTH_C) | pop);

    // Once out of BOOT, RUN vs HALTED simply follows the Halt level.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT:   state_d = Halt ? ST_HALTED : ST_RUN;
            ST_RUN:    state_d = Halt ? ST_HALTED : ST_RUN;
            ST_HALTED: state_d = Halt ? ST_HALTED : ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Redirect) begin
            pc_d     = {RedirectTarget[DATA_WIDTH-1:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + DATA_WIDTH'(4);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            valid_q       <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            valid_q       <= (count_d != '0);
            misalign_q    <= Redirect & (RedirectTarget[1:0] != 2'b00);
            fetch_count_q <= fetch_count_q + DATA_WIDTH'(pop);
        end
    end

    // Storage entries are cleared on reset so the head reads zero until the first fetch.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    instr_mem_q[gi] <= '0;
                    pc_mem_q[gi]    <= '0;
                end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    instr_mem_q[gi] <= Instruction;
                    pc_mem_q[gi]    <= pc_q;
                end
            end
        end
    endgenerate

    assign PcAddress   = pc_q;
    assign InstrValid  = valid_q;
    assign InstrOut    = instr_mem_q[rd_ptr_q];
    assign InstrPc     = pc_mem_q[rd_ptr_q];
    assign MisalignErr = misalign_q;
    assign FetchCount  = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised bench for instruction_fetch_unit against a queue-based model of
// the fetch pipeline, with directed phases for reset, backpressure, redirect and halt.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PcAddress;
    logic [31:0] Instruction;
    logic        Halt = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectTarget = '0;
    logic        InstrValid;
    logic [31:0] InstrOut;
    logic [31:0] InstrPc;
    logic        DecodeReady = 1'b0;
    logic        MisalignErr;
    logic [31:0] FetchCount;

    int n_vec = 0;
    int n_err = 0;

    // ROM word at byte address a is its word index from RESET_PC, plus one.
    function automatic logic [31:0] rom(input logic [31:0] a);
        logic [31:0] d;
        d = a - RPC;
        return (d >> 2) + 32'd1;
    endfunction

    assign Instruction = rom(PcAddress);

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (RPC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .PcAddress      (PcAddress),
        .Instruction    (Instruction),
        .Halt           (Halt),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .InstrValid     (InstrValid),
        .InstrOut       (InstrOut),
        .InstrPc        (InstrPc),
        .DecodeReady    (DecodeReady),
        .MisalignErr    (MisalignErr),
        .FetchCount     (FetchCount)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: queue of fetched words, fetch PC, accepted count, and whether fetching is enabled.
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_run;
    logic        m_mis;
    logic [31:0] mq_instr[$];
    logic [31:0] mq_pc[$];

    task automatic model_reset();
        m_pc  = RPC;
        m_cnt = 0;
        m_run = 1'b0;
        m_mis = 1'b0;
        mq_instr.delete();
        mq_pc.delete();
    endtask

    task automatic cycle(input logic h, input logic r, input logic [31:0] t, input logic rdy);
        logic pop;
        logic fetch;
        @(negedge clk);
        check_eq("InstrValid", 32'(InstrValid), 32'(mq_pc.size() != 0));
        if (mq_pc.size() != 0) begin
            check_eq("InstrOut", InstrOut, mq_instr[0]);
            check_eq("InstrPc", InstrPc, mq_pc[0]);
        end
        check_eq("PcAddress", PcAddress, m_pc);
        check_eq("MisalignErr", 32'(MisalignErr), 32'(m_mis));
        check_eq("FetchCount", FetchCount, m_cnt);

        Halt           = h;
        Redirect       = r;
        RedirectTarget = t;
        DecodeReady    = rdy;

        pop   = (mq_pc.size() != 0) && rdy;
        fetch = m_run && !h && !r && ((mq_pc.size() < 2) || pop);
        if (pop) begin
            $display("accept pc=%h instr=%h", mq_pc[0], mq_instr[0]);
            void'(mq_instr.pop_front());
            void'(mq_pc.pop_front());
            m_cnt = m_cnt + 1;
        end
        if (r) begin
            mq_instr.delete();
            mq_pc.delete();
            m_pc = {t[31:2], 2'b00};
        end else if (fetch) begin
            mq_instr.push_back(rom(m_pc));
            mq_pc.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        m_mis = r && (t[1:0] != 2'b00);
        m_run = !h;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check_eq("rst InstrValid", 32'(InstrValid), 32'd0);
        check_eq("rst PcAddress", PcAddress, RPC);
        check_eq("rst FetchCount", FetchCount, 32'd0);
        check_eq("rst MisalignErr", 32'(MisalignErr), 32'd0);
        check_eq("rst InstrOut", InstrOut, 32'd0);
        check_eq("rst InstrPc", InstrPc, 32'd0);
        model_reset();
        Halt        = 1'b0;
        Redirect    = 1'b0;
        DecodeReady = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            logic h, r, rdy;
            logic [31:0] t;
            h   = ($urandom_range(99) < 15);
            r   = ($urandom_range(99) < 10);
            rdy = ($urandom_range(99) < 70);
            t   = RPC + 32'($urandom_range(255));
            cycle(h, r, t, rdy);
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // Straight-line streaming with decode always ready.
        repeat (8) cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Backpressure from reset: FIFO fills, then drains without bubbles.
        do_reset();
        repeat (6) cycle(1'b0, 1'b0, 32'd0, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Redirect with a full FIFO, then a misaligned redirect.
        repeat (4) cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 32'h0040_0040, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b1, 32'h0040_0042, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Halt with entries queued, redirect while halted, then resume.
        repeat (3) cycle(1'b0, 1'b0, 32'd0, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 32'd0, 1'b1);
        cycle(1'b1, 1'b1, 32'h0040_0080, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, 32'd0, 1'b1);

        random_phase(300);

        // Reset in the middle of a stream with the FIFO occupied.
        repeat (4) cycle(1'b0, 1'b0, 32'd0, 1'b0);
        do_reset();
        repeat (8) cycle(1'b0, 1'b0, 32'd0, 1'b1);

        random_phase(150);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
